alu_exec: RTL

Sequential ALU execution stage that consumes the 3-bit operation select produced by the button-driven operation selector, plus two operands. On a start pulse it latches `sel`, `a` and `b`, executes the operation and returns a registered result with a one-cycle `done` pulse. ADD/SUB/AND/XOR complete in one cycle. MUL (shift-add) and DIV (restoring) iterate one bit per cycle, so the whole block stays small enough for the FinalExam board build.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_iter_muldiv.sv | 84 ++++++++
 rtl/alu_exec.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution stage: opcodes (also used by the
// button-driven operation selector) and the control FSM encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_DIV = 3'd5;

    // IDLE: waiting for a request. ITER: multi-cycle MUL/DIV stepping.
    // DONE: operands/results settled, outputs published on the next edge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for opcodes handled by the iterative datapath.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned datapath: shift-add multiply and restoring divide, one
// bit per step. A single pair of WIDTH-bit registers holds either the
// {high, low} product halves or the {remainder, quotient} pair.
module alu_iter_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam logic [WIDTH-1:0] CNT_LOAD = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] dv;
    logic [WIDTH-1:0] cnt;
    logic             mode;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    // Next-step values: MUL adds the multiplicand when the current multiplier
    // bit is set then shifts right; DIV shifts in the next dividend bit and
    // subtracts the divisor when it fits (a zero divisor always "fits").
    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, dv} : {(WIDTH + 1){1'b0}});
        shifted = {hi, lo[WIDTH-1]};
        trial   = shifted[WIDTH-1:0] - dv;
        if (mode) begin
            if (shifted >= {1'b0, dv}) begin
                nxt_hi = trial;
                nxt_lo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[WIDTH-1:0];
                nxt_lo = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = add_sum[WIDTH:1];
            nxt_lo = {add_sum[0], lo[WIDTH-1:1]};
        end
    end

    // Operand load and per-cycle stepping with a down-counting bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            dv   <= '0;
            cnt  <= '0;
            mode <= 1'b0;
        end else if (load) begin
            hi   <= '0;
            lo   <= div_mode ? a : b;
            dv   <= div_mode ? b : a;
            cnt  <= CNT_LOAD;
            mode <= div_mode;
        end else if (step) begin
            hi <= nxt_hi;
            lo <= nxt_lo;
            if (cnt != '0) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    assign last      = (cnt == '0);
    assign product   = {hi, lo};
    assign quotient  = lo;
    assign remainder = hi;

endmodule

// File: rtl/alu_exec.sv
// Sequential ALU execution stage. Latches sel/a/b on an accepted start,
// evaluates single-cycle ops directly and MUL/DIV through the iterative
// datapath, then publishes result/carry/err with a one-cycle done pulse.
//
// Handshake: start is a request sampled on a rising edge only while busy=0;
// once accepted, busy stays high until the edge that raises done, and all
// inputs are ignored in between. done marks the single cycle in which
// result/carry/err took their new values; they hold until the next done.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         sel,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               err
);

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic               md_load;
    logic               md_step;
    logic               md_last;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] res_c;
    logic               carry_c;
    logic               err_c;

    // The iterative datapath captures the raw inputs on the accepting edge.
    assign md_load = (state == ST_IDLE) && start && is_iter_op(sel);
    assign md_step = (state == ST_ITER);

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .load      (md_load),
        .step      (md_step),
        .div_mode  (sel == OP_DIV),
        .a         (a),
        .b         (b),
        .last      (md_last),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Result selection from the latched operands; borrow is the sign bit of
    // the widened difference.
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        res_c   = '0;
        carry_c = 1'b0;
        err_c   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_c   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                carry_c = sum[WIDTH];
            end
            OP_SUB: begin
                res_c   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                carry_c = diff[WIDTH];
            end
            OP_AND:  res_c = {{WIDTH{1'b0}}, a_q & b_q};
            OP_XOR:  res_c = {{WIDTH{1'b0}}, a_q ^ b_q};
            OP_MUL:  res_c = product;
            OP_DIV: begin
                res_c = {remainder, quotient};
                err_c = (b_q == '0);
            end
            default: err_c = 1'b1;
        endcase
    end

    // Control FSM with registered busy/done and published outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= sel;
                        a_q   <= a;
                        b_q   <= b;
                        busy  <= 1'b1;
                        state <= is_iter_op(sel) ? ST_ITER : ST_DONE;
                    end
                end
                ST_ITER: begin
                    if (md_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    result <= res_c;
                    carry  <= carry_c;
                    err    <= err_c;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
